// File: rtl/reg_file_pkg.sv
// Shared sizing for the renamed architectural register file.
// The ROB id width and register count must match the reorder buffer's.
package reg_file_pkg;
  localparam int ROB_WIDTH = 4;
  localparam int REG_NUM   = 32;
  localparam int XLEN      = 32;
  localparam logic [4:0] X0_IDX = 5'd0;
endpackage

// File: rtl/reg_file_read_port.sv
// One source-operand lookup: x0 / not-busy / commit-forward / dependency select.
// Purely combinational; the top registers the result.
module reg_file_read_port
  import reg_file_pkg::*;
#(
  parameter int ROB_W = ROB_WIDTH
) (
  input  logic [4:0]       rs,
  input  logic             busy,
  input  logic [ROB_W-1:0] tag,
  input  logic [XLEN-1:0]  val,
  input  logic             commit_ready,
  input  logic [ROB_W-1:0] commit_rob_id,
  input  logic [4:0]       commit_reg_id,
  input  logic [XLEN-1:0]  commit_val,
  output logic             has_dep,
  output logic [ROB_W-1:0] rob_id,
  output logic [XLEN-1:0]  data
);

  logic forward;

  // The retiring producer is exactly the one this register waits on.
  assign forward = commit_ready && (commit_reg_id == rs) && (commit_rob_id == tag);

  always_comb begin
    has_dep = 1'b0;
    rob_id  = '0;
    data    = '0;
    if (rs != X0_IDX) begin
      if (!busy) begin
        data = val;
      end else if (forward) begin
        data = commit_val;
      end else begin
        has_dep = 1'b1;
        rob_id  = tag;
      end
    end
  end

endmodule

// File: rtl/reg_file.sv
// Architectural register file with busy flags and ROB rename tags.
// Two registered source lookups feed the ROB's search inputs one cycle later.
module reg_file
  import reg_file_pkg::*;
#(
  parameter int ROB_W = ROB_WIDTH
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear,
  input  logic             dec_ready,
  input  logic [4:0]       dec_rd,
  input  logic [ROB_W-1:0] dec_rob_id,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic             commit_ready,
  input  logic [ROB_W-1:0] commit_rob_id,
  input  logic [4:0]       commit_reg_id,
  input  logic [XLEN-1:0]  commit_val,
  output logic             search_in_has_dep_1,
  output logic [ROB_W-1:0] search_rob_id_1,
  output logic [XLEN-1:0]  search_in_val_1,
  output logic             search_in_has_dep_2,
  output logic [ROB_W-1:0] search_rob_id_2,
  output logic [XLEN-1:0]  search_in_val_2
);

  logic [XLEN-1:0]  rf_val  [REG_NUM];
  logic             rf_busy [REG_NUM];
  logic [ROB_W-1:0] rf_tag  [REG_NUM];

  for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_reg
    if (gi == 0) begin : g_x0
      assign rf_val[gi]  = '0;
      assign rf_busy[gi] = 1'b0;
      assign rf_tag[gi]  = '0;
    end else begin : g_rn
      localparam logic [4:0] IDX = 5'(gi);
      logic [XLEN-1:0]  val_reg;
      logic             busy_reg;
      logic [ROB_W-1:0] tag_reg;
      logic             issue_hit;
      logic             commit_hit;

      assign issue_hit  = dec_ready && (dec_rd == IDX);
      assign commit_hit = commit_ready && (commit_reg_id == IDX);

      // Clear beats issue, issue beats a same-cycle commit; values survive clear.
      always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
          val_reg  <= '0;
          busy_reg <= 1'b0;
          tag_reg  <= '0;
        end else if (rdy_in) begin
          if (commit_hit) begin
            val_reg <= commit_val;
          end
          if (clear) begin
            busy_reg <= 1'b0;
            tag_reg  <= '0;
          end else if (issue_hit) begin
            busy_reg <= 1'b1;
            tag_reg  <= dec_rob_id;
          end else if (commit_hit && (tag_reg == commit_rob_id)) begin
            busy_reg <= 1'b0;
          end
        end
      end

      assign rf_val[gi]  = val_reg;
      assign rf_busy[gi] = busy_reg;
      assign rf_tag[gi]  = tag_reg;
    end
  end

  logic             dep_1, dep_2;
  logic [ROB_W-1:0] tag_1, tag_2;
  logic [XLEN-1:0]  data_1, data_2;

  reg_file_read_port #(.ROB_W(ROB_W)) u_port_1 (
    .rs            (dec_rs1),
    .busy          (rf_busy[dec_rs1]),
    .tag           (rf_tag[dec_rs1]),
    .val           (rf_val[dec_rs1]),
    .commit_ready  (commit_ready),
    .commit_rob_id (commit_rob_id),
    .commit_reg_id (commit_reg_id),
    .commit_val    (commit_val),
    .has_dep       (dep_1),
    .rob_id        (tag_1),
    .data          (data_1)
  );

  reg_file_read_port #(.ROB_W(ROB_W)) u_port_2 (
    .rs            (dec_rs2),
    .busy          (rf_busy[dec_rs2]),
    .tag           (rf_tag[dec_rs2]),
    .val           (rf_val[dec_rs2]),
    .commit_ready  (commit_ready),
    .commit_rob_id (commit_rob_id),
    .commit_reg_id (commit_reg_id),
    .commit_val    (commit_val),
    .has_dep       (dep_2),
    .rob_id        (tag_2),
    .data          (data_2)
  );

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      search_in_has_dep_1 <= 1'b0;
      search_rob_id_1     <= '0;
      search_in_val_1     <= '0;
      search_in_has_dep_2 <= 1'b0;
      search_rob_id_2     <= '0;
      search_in_val_2     <= '0;
    end else if (rdy_in) begin
      search_in_has_dep_1 <= dep_1;
      search_rob_id_1     <= tag_1;
      search_in_val_1     <= data_1;
      search_in_has_dep_2 <= dep_2;
      search_rob_id_2     <= tag_2;
      search_in_val_2     <= data_2;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus random traffic
// compared against an array-based model of the rename/commit/clear rules.
module tb_reg_file;
  import reg_file_pkg::*;

  logic                 clk_in = 1'b0;
  logic                 rst_in;
  logic                 rdy_in;
  logic                 clear;
  logic                 dec_ready;
  logic [4:0]           dec_rd;
  logic [ROB_WIDTH-1:0] dec_rob_id;
  logic [4:0]           dec_rs1;
  logic [4:0]           dec_rs2;
  logic                 commit_ready;
  logic [ROB_WIDTH-1:0] commit_rob_id;
  logic [4:0]           commit_reg_id;
  logic [31:0]          commit_val;
  logic                 search_in_has_dep_1;
  logic [ROB_WIDTH-1:0] search_rob_id_1;
  logic [31:0]          search_in_val_1;
  logic                 search_in_has_dep_2;
  logic [ROB_WIDTH-1:0] search_rob_id_2;
  logic [31:0]          search_in_val_2;

  always #5 clk_in = ~clk_in;

  reg_file dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .rdy_in              (rdy_in),
    .clear               (clear),
    .dec_ready           (dec_ready),
    .dec_rd              (dec_rd),
    .dec_rob_id          (dec_rob_id),
    .dec_rs1             (dec_rs1),
    .dec_rs2             (dec_rs2),
    .commit_ready        (commit_ready),
    .commit_rob_id       (commit_rob_id),
    .commit_reg_id       (commit_reg_id),
    .commit_val          (commit_val),
    .search_in_has_dep_1 (search_in_has_dep_1),
    .search_rob_id_1     (search_rob_id_1),
    .search_in_val_1     (search_in_val_1),
    .search_in_has_dep_2 (search_in_has_dep_2),
    .search_rob_id_2     (search_rob_id_2),
    .search_in_val_2     (search_in_val_2)
  );

  int errors = 0;
  int checks = 0;

  // Reference state: architectural values, busy flags, newest producer tags.
  logic [31:0]          m_val  [REG_NUM];
  logic                 m_busy [REG_NUM];
  logic [ROB_WIDTH-1:0] m_tag  [REG_NUM];

  logic                 e_dep1, e_dep2;
  logic [ROB_WIDTH-1:0] e_tag1, e_tag2;
  logic [31:0]          e_val1, e_val2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < REG_NUM; i++) begin
      m_val[i]  = '0;
      m_busy[i] = 1'b0;
      m_tag[i]  = '0;
    end
    e_dep1 = 0; e_tag1 = '0; e_val1 = '0;
    e_dep2 = 0; e_tag2 = '0; e_val2 = '0;
  endfunction

  function automatic void lookup(input logic [4:0] r, output logic dep,
                                 output logic [ROB_WIDTH-1:0] t, output logic [31:0] v);
    dep = 1'b0; t = '0; v = '0;
    if (r == 0) return;
    if (!m_busy[r]) v = m_val[r];
    else if (commit_ready && commit_reg_id == r && commit_rob_id == m_tag[r]) v = commit_val;
    else begin dep = 1'b1; t = m_tag[r]; end
  endfunction

  function automatic void model_update();
    if (commit_ready && commit_reg_id != 0) begin
      m_val[commit_reg_id] = commit_val;
      if (m_tag[commit_reg_id] == commit_rob_id) m_busy[commit_reg_id] = 1'b0;
    end
    if (clear) begin
      for (int i = 0; i < REG_NUM; i++) begin
        m_busy[i] = 1'b0;
        m_tag[i]  = '0;
      end
    end else if (dec_ready && dec_rd != 0) begin
      m_busy[dec_rd] = 1'b1;
      m_tag[dec_rd]  = dec_rob_id;
    end
  endfunction

  // One clock: predict, advance the model, then compare all six outputs.
  task automatic step(input string name);
    if (rdy_in) begin
      lookup(dec_rs1, e_dep1, e_tag1, e_val1);
      lookup(dec_rs2, e_dep2, e_tag2, e_val2);
      model_update();
    end
    @(posedge clk_in);
    #1;
    check({name, ".dep1"}, 32'(search_in_has_dep_1), 32'(e_dep1));
    check({name, ".tag1"}, 32'(search_rob_id_1), 32'(e_tag1));
    check({name, ".val1"}, search_in_val_1, e_val1);
    check({name, ".dep2"}, 32'(search_in_has_dep_2), 32'(e_dep2));
    check({name, ".tag2"}, 32'(search_rob_id_2), 32'(e_tag2));
    check({name, ".val2"}, search_in_val_2, e_val2);
  endtask

  task automatic idle();
    rdy_in = 1'b1; clear = 1'b0; dec_ready = 1'b0; commit_ready = 1'b0;
    dec_rd = '0; dec_rob_id = '0; commit_rob_id = '0; commit_reg_id = '0; commit_val = '0;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [ROB_WIDTH-1:0] id);
    dec_ready = 1'b1; dec_rd = rd; dec_rob_id = id;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [ROB_WIDTH-1:0] id, input logic [31:0] v);
    commit_ready = 1'b1; commit_reg_id = rd; commit_rob_id = id; commit_val = v;
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".dep1"}, 32'(search_in_has_dep_1), 32'd0);
    check({name, ".tag1"}, 32'(search_rob_id_1), 32'd0);
    check({name, ".val1"}, search_in_val_1, 32'd0);
    check({name, ".dep2"}, 32'(search_in_has_dep_2), 32'd0);
    check({name, ".tag2"}, 32'(search_rob_id_2), 32'd0);
    check({name, ".val2"}, search_in_val_2, 32'd0);
  endtask

  initial begin
    idle();
    dec_rs1 = '0; dec_rs2 = '0;
    rst_in = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    check_all_zero("reset");
    @(negedge clk_in);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1;

    // Commit without rename, then read it back.
    idle(); commit(5'd5, 4'd0, 32'h1234); step("t2_commit");
    idle(); dec_rs1 = 5'd5; step("t2_lookup");
    check("t2_val_x5", search_in_val_1, 32'h1234);

    // Rename, dependency, then same-cycle commit forwarding.
    idle(); issue(5'd7, 4'd3); dec_rs1 = 5'd0; dec_rs2 = 5'd7; step("t3_issue");
    check("t3_no_self_dep", 32'(search_in_has_dep_2), 32'd0);
    idle(); dec_rs2 = 5'd7; step("t3_dep");
    check("t3_tag", 32'(search_rob_id_2), 32'd3);
    idle(); commit(5'd7, 4'd3, 32'hAA); step("t3_fwd");
    check("t3_fwd_val", search_in_val_2, 32'hAA);

    // Stale commit leaves the newer rename in place.
    idle(); issue(5'd7, 4'd2); step("t4_iss2");
    idle(); issue(5'd7, 4'd5); step("t4_iss5");
    idle(); commit(5'd7, 4'd2, 32'h11); step("t4_stale");
    idle(); dec_rs1 = 5'd7; step("t4_lookup");
    check("t4_tag5", 32'(search_rob_id_1), 32'd5);

    // Clear drops the same-cycle issue and every outstanding rename.
    idle(); issue(5'd9, 4'd4); clear = 1'b1; step("t5_clear");
    idle(); dec_rs1 = 5'd9; dec_rs2 = 5'd7; step("t5_lookup");
    check("t5_x7_val", search_in_val_2, 32'h11);

    // x0 is immune to writes; rdy_in low freezes everything.
    idle(); issue(5'd0, 4'd1); commit(5'd0, 4'd1, 32'hFFFF); dec_rs1 = 5'd0; step("t6_x0w");
    idle(); dec_rs1 = 5'd0; dec_rs2 = 5'd7; step("t6_x0r");
    idle(); rdy_in = 1'b0; commit(5'd3, 4'd0, 32'h77); issue(5'd3, 4'd6);
    dec_rs1 = 5'd3; dec_rs2 = 5'd9; step("t6_hold");
    check("t6_hold_val2", search_in_val_2, 32'h11);
    idle(); dec_rs1 = 5'd3; step("t6_after");
    check("t6_x3_unwritten", search_in_val_1, 32'd0);

    // Random traffic on a small register window to force collisions.
    for (int n = 0; n < 600; n++) begin
      logic [4:0] cr;
      idle();
      rdy_in    = ($urandom_range(0, 7) != 0);
      clear     = ($urandom_range(0, 19) == 0);
      dec_ready = ($urandom_range(0, 1) == 1);
      dec_rd    = 5'($urandom_range(0, 7));
      dec_rob_id = ROB_WIDTH'($urandom_range(0, 15));
      dec_rs1   = 5'($urandom_range(0, 7));
      dec_rs2   = 5'($urandom_range(0, 7));
      cr = 5'($urandom_range(0, 7));
      commit_ready  = ($urandom_range(0, 1) == 1);
      commit_reg_id = cr;
      commit_rob_id = ($urandom_range(0, 2) != 0) ? m_tag[cr] : ROB_WIDTH'($urandom_range(0, 15));
      commit_val    = $urandom;
      step("rand");
    end

    // Asynchronous reset mid-run with populated state.
    idle(); commit(5'd5, 4'd0, 32'hCAFE); dec_rs1 = 5'd5; dec_rs2 = 5'd5; step("t1_fill");
    idle(); dec_rs1 = 5'd5; dec_rs2 = 5'd5; step("t1_pre");
    rst_in = 1'b0;
    #2;
    check_all_zero("t1_async");
    model_reset();
    @(negedge clk_in);
    rst_in = 1'b1;
    idle(); dec_rs1 = 5'd5; dec_rs2 = 5'd0; step("t1_after");
    check("t1_x5_cleared", search_in_val_1, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
